// File: rtl/patch_dump_pkg.sv
// Shared types and constants for the SysEx patch dump sequencer.
// Section order and tag bytes define the layout of the dump stream.
package patch_dump_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_REQ,
        ST_RD,
        ST_CAP,
        ST_TX,
        ST_TAG,
        ST_CHK,
        ST_EOX
    } state_t;

    typedef enum logic [1:0] {
        SEC_COM,
        SEC_OSC,
        SEC_M1,
        SEC_M2
    } sec_t;

    localparam logic [7:0] SYX_SOX = 8'hF0;
    localparam logic [7:0] SYX_EOX = 8'hF7;
    localparam logic [7:0] TAG_COM = 8'h01;
    localparam logic [7:0] TAG_OSC = 8'h02;
    localparam logic [7:0] TAG_M1  = 8'h03;
    localparam logic [7:0] TAG_M2  = 8'h04;
    localparam int         COM_LEN = 32;

    // Number of registers in a section; OSC/M1/M2 scale with the oscillator count.
    function automatic logic [7:0] sec_len(input sec_t sec, input int v_osc);
        if (sec == SEC_COM) begin
            return 8'(COM_LEN);
        end
        return 8'(v_osc * 16);
    endfunction

    function automatic logic [7:0] sec_tag(input sec_t sec);
        case (sec)
            SEC_COM: return TAG_COM;
            SEC_OSC: return TAG_OSC;
            SEC_M1:  return TAG_M1;
            default: return TAG_M2;
        endcase
    endfunction

endpackage

// File: rtl/patch_dump_sequencer_cksum.sv
// 7-bit SysEx checksum accumulator: running sum of tag and data bytes,
// presented as the two's-complement value that brings the total to zero mod 128.
module sysex_cksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [6:0] data_byte,
    output logic [6:0] chk
);

    logic [6:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 7'd0;
        end else if (clr) begin
            sum_q <= 7'd0;
        end else if (add_en) begin
            sum_q <= sum_q + data_byte;
        end
    end

    assign chk = 7'd0 - sum_q;

endmodule

// File: rtl/patch_dump_sequencer.sv
// Walks the COM/OSC/M1/M2 register spaces and streams them out as a SysEx
// patch dump, sharing the register-file port with the host via req/gnt.
module patch_dump_sequencer
    import patch_dump_pkg::*;
#(
    parameter int         V_OSC  = 4,
    parameter logic [7:0] MFR_ID = 8'h7D,
    parameter logic [7:0] DEV_ID = 8'h00
) (
    input  logic       data_clk,
    input  logic       reset_data_N,
    input  logic       start,
    input  logic       abort,
    input  logic       bus_gnt,
    input  logic [7:0] rd_data,
    input  logic       out_ready,
    output logic       bus_req,
    output logic [6:0] adr,
    output logic       read,
    output logic       osc_sel,
    output logic       com_sel,
    output logic       m1_sel,
    output logic       m2_sel,
    output logic       sysex_data_patch_send,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    if (V_OSC * 16 > 128 || V_OSC < 1) begin : g_bad_vosc
        $error("V_OSC must satisfy 1 <= V_OSC and V_OSC*16 <= 128");
    end

    state_t     state_q, state_d;
    sec_t       sec_q, sec_d;
    logic [6:0] adr_q, adr_d;
    logic [1:0] hdr_q, hdr_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ck_clr, ck_add;
    logic [6:0] chk;
    logic [6:0] last_adr;
    logic [3:0] sel_vec;

    assign last_adr = 7'(sec_len(sec_q, V_OSC) - 8'd1);

    always_ff @(posedge data_clk or negedge reset_data_N) begin
        if (!reset_data_N) begin
            state_q <= ST_IDLE;
            sec_q   <= SEC_COM;
            adr_q   <= 7'd0;
            hdr_q   <= 2'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            adr_q   <= adr_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        adr_d     = adr_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ck_clr    = 1'b0;
        ck_add    = 1'b0;
        bus_req   = 1'b0;
        read      = 1'b0;
        adr       = 7'd0;
        sel_vec   = 4'b0000;
        out_valid = 1'b0;
        out_data  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                ck_clr = 1'b1;
                if (start && !abort) begin
                    state_d = ST_HDR;
                    hdr_d   = 2'd0;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = (hdr_q == 2'd0) ? SYX_SOX :
                            (hdr_q == 2'd1) ? MFR_ID  : DEV_ID;
                if (out_ready) begin
                    if (hdr_q == 2'd2) begin
                        state_d = ST_TAG;
                        sec_d   = SEC_COM;
                    end else begin
                        hdr_d = hdr_q + 2'd1;
                    end
                end
            end
            ST_TAG: begin
                out_valid = 1'b1;
                out_data  = sec_tag(sec_q);
                if (out_ready) begin
                    ck_add  = 1'b1;
                    adr_d   = 7'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                bus_req = 1'b1;
                read    = 1'b1;
                adr     = adr_q;
                sel_vec = 4'b0001 << sec_q;
                state_d = bus_gnt ? ST_CAP : ST_REQ;
            end
            ST_CAP: begin
                // Register file answers one cycle after the strobe; a lost grant forces a re-read.
                bus_req = 1'b1;
                adr     = adr_q;
                sel_vec = 4'b0001 << sec_q;
                if (bus_gnt) begin
                    data_d  = rd_data & 8'h7F;
                    state_d = ST_TX;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_TX: begin
                out_valid = 1'b1;
                out_data  = data_q;
                if (out_ready) begin
                    ck_add = 1'b1;
                    if (adr_q == last_adr) begin
                        if (sec_q == SEC_M2) begin
                            state_d = ST_CHK;
                        end else begin
                            sec_d   = sec_t'(sec_q + 2'd1);
                            state_d = ST_TAG;
                        end
                    end else begin
                        adr_d   = adr_q + 7'd1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_CHK: begin
                out_valid = 1'b1;
                out_data  = {1'b0, chk};
                if (out_ready) begin
                    state_d = ST_EOX;
                end
            end
            ST_EOX: begin
                out_valid = 1'b1;
                out_data  = SYX_EOX;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides any transfer or advance decided above.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            ck_add  = 1'b0;
            ck_clr  = 1'b1;
            done_d  = 1'b0;
        end
    end

    sysex_cksum u_cksum (
        .clk       (data_clk),
        .rst_n     (reset_data_N),
        .clr       (ck_clr),
        .add_en    (ck_add),
        .data_byte (out_data[6:0]),
        .chk       (chk)
    );

    assign com_sel               = sel_vec[0];
    assign osc_sel               = sel_vec[1];
    assign m1_sel                = sel_vec[2];
    assign m2_sel                = sel_vec[3];
    assign busy                  = (state_q != ST_IDLE);
    assign sysex_data_patch_send = busy;
    assign done                  = done_q;

endmodule

// File: tb/tb_patch_dump_sequencer.sv
// Scoreboard bench for patch_dump_sequencer: expected bytes are queued per dump,
// a negedge monitor pops and compares every accepted byte.
module tb_patch_dump_sequencer;

    logic       data_clk = 1'b0;
    logic       reset_data_N = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bus_gnt = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       bus_req, read, osc_sel, com_sel, m1_sel, m2_sel;
    logic       sysex_data_patch_send, out_valid, busy, done;
    logic [6:0] adr;
    logic [7:0] out_data;

    patch_dump_sequencer dut (
        .data_clk              (data_clk),
        .reset_data_N          (reset_data_N),
        .start                 (start),
        .abort                 (abort),
        .bus_gnt               (bus_gnt),
        .rd_data               (rd_data),
        .out_ready             (out_ready),
        .bus_req               (bus_req),
        .adr                   (adr),
        .read                  (read),
        .osc_sel               (osc_sel),
        .com_sel               (com_sel),
        .m1_sel                (m1_sel),
        .m2_sel                (m2_sel),
        .sysex_data_patch_send (sysex_data_patch_send),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 data_clk = ~data_clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         xfer_cnt = 0;
    int         busy_cycles = 0;
    int         rd12_cnt = 0;
    logic [7:0] last_chk = 8'h00;
    logic [7:0] prev_byte = 8'h00;
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;
    bit         bp_mode = 1'b0;
    bit         rd_mode = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [24:0] all_outs();
        return {bus_req, adr, read, osc_sel, com_sel, m1_sel, m2_sel,
                sysex_data_patch_send, out_data, out_valid, busy, done};
    endfunction

    // Register file: answers one cycle after the read strobe.
    always @(posedge data_clk) begin
        if (read) begin
            rd_data <= rd_mode ? 8'hC3 :
                       {1'b0, adr ^ {m1_sel | m2_sel, osc_sel | m2_sel, 5'b0}};
        end
    end

    initial begin
        forever begin
            @(posedge data_clk);
            #1;
            out_ready = bp_mode ? ~out_ready : 1'b1;
        end
    end

    always @(negedge data_clk) begin
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (read && osc_sel && adr == 7'h12) rd12_cnt++;
        if (out_valid && stall_q) check("hold_stable", out_data, stall_data);
        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_extra: got=%0h expected=none", out_data);
            end else begin
                check("stream_byte", out_data, exp_q.pop_front());
            end
            if (out_data == 8'hF7) last_chk = prev_byte;
            prev_byte = out_data;
            xfer_cnt++;
        end
    end

    function automatic void push_expected(input bit mode);
        int         sum;
        logic [7:0] d;
        sum = 0;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back(8'h00);
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back(8'(s + 1));
            sum += s + 1;
            for (int a = 0; a < ((s == 0) ? 32 : 64); a++) begin
                d = mode ? 8'h43 : 8'((a ^ (s << 5)) & 8'h7F);
                exp_q.push_back(d);
                sum += int'(d);
            end
        end
        exp_q.push_back(8'((128 - (sum % 128)) & 8'h7F));
        exp_q.push_back(8'hF7);
    endfunction

    task automatic run_dump(input bit mode);
        rd_mode     = mode;
        busy_cycles = 0;
        xfer_cnt    = 0;
        rd12_cnt    = 0;
        push_expected(mode);
        start = 1'b1;
        @(negedge data_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 5000) begin
            @(negedge data_clk);
            n++;
        end
        repeat (3) @(negedge data_clk);
        check("done_count", done_cnt, target);
    endtask

    task automatic check_stream(input string tag, input int chk_exp);
        check({tag, "_bytes"}, xfer_cnt, 233);
        check({tag, "_chk"}, last_chk, chk_exp);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge data_clk);
        check("reset_outputs", all_outs(), 0);
        reset_data_N = 1'b1;
        @(negedge data_clk);

        // Full dump, no stalls.
        run_dump(1'b0);
        check("first_byte_f0", {busy, out_valid, out_data}, {2'b11, 8'hF0});
        wait_done(1);
        check_stream("full", 8'h66);
        check("full_cycles", busy_cycles, 685);

        // Backpressure: ready toggles every cycle.
        bp_mode = 1'b1;
        run_dump(1'b0);
        wait_done(2);
        check_stream("bp", 8'h66);
        bp_mode = 1'b0;
        @(negedge data_clk);

        // Grant lost for 2 cycles during CAP at OSC address 0x12.
        run_dump(1'b0);
        n = 0;
        while (!(osc_sel && !read && bus_req && adr == 7'h12) && n < 5000) begin
            @(negedge data_clk);
            n++;
        end
        check("gnt_drop_reached", n < 5000 ? 1 : 0, 1);
        bus_gnt = 1'b0;
        repeat (2) @(negedge data_clk);
        bus_gnt = 1'b1;
        wait_done(3);
        check_stream("gnt", 8'h66);
        check("gnt_reread", rd12_cnt, 2);
        check("gnt_cycles", busy_cycles, 689);

        // Abort during M1 address 5.
        run_dump(1'b0);
        n = 0;
        while (!(m1_sel && read && adr == 7'd5) && n < 5000) begin
            @(negedge data_clk);
            n++;
        end
        check("abort_reached", n < 5000 ? 1 : 0, 1);
        abort = 1'b1;
        @(negedge data_clk);
        abort = 1'b0;
        check("abort_outputs",
              {busy, com_sel, osc_sel, m1_sel, m2_sel, out_valid, bus_req, read}, 0);
        exp_q.delete();
        repeat (5) @(negedge data_clk);
        check("abort_no_done", done_cnt, 3);
        run_dump(1'b0);
        wait_done(4);
        check_stream("after_abort", 8'h66);

        // Bit 7 masking, and a start pulse while busy.
        run_dump(1'b1);
        repeat (50) @(negedge data_clk);
        start = 1'b1;
        @(negedge data_clk);
        start = 1'b0;
        wait_done(5);
        check_stream("c3", 8'h56);

        // start together with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge data_clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", busy, 0);
        repeat (3) @(negedge data_clk);
        check("start_abort_no_done", done_cnt, 5);

        // Asynchronous reset mid-dump, then a clean restart.
        run_dump(1'b0);
        repeat (100) @(negedge data_clk);
        #2 reset_data_N = 1'b0;
        #1 check("reset_mid_outputs", all_outs(), 0);
        exp_q.delete();
        @(negedge data_clk);
        reset_data_N = 1'b1;
        @(negedge data_clk);
        run_dump(1'b0);
        check("restart_f0", {busy, out_valid, out_data}, {2'b11, 8'hF0});
        wait_done(6);
        check_stream("restart", 8'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
